// File: rtl/mod_gen_pkg.sv
// Shared types and helpers for the multi-phase modulation generator.
// Pure declarations and functions; adds no clock latency.
// No flow control; nothing here holds state.
package mod_gen_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int PHASE_W = 3;

    // Force the requested phase count into [2, max_n].
    function automatic logic [3:0] clamp_nphase(input logic [7:0] n, input logic [3:0] max_n);
        if (n < 8'd2) begin
            return 4'd2;
        end else if (n > {4'b0000, max_n}) begin
            return max_n;
        end else begin
            return n[3:0];
        end
    endfunction

    // Signed add of two sign-extended operands, clamped to the range of a w-bit signed value.
    // The caller keeps the low w bits of the result.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned       w);
        logic signed [64:0] s;
        logic signed [64:0] maxv;
        logic signed [64:0] minv;
        s    = {a[63], a} + {b[63], b};
        maxv = (65'sd1 <<< (w - 1)) - 65'sd1;
        minv = -(65'sd1 <<< (w - 1));
        if (s > maxv) begin
            return maxv[63:0];
        end else if (s < minv) begin
            return minv[63:0];
        end else begin
            return s[63:0];
        end
    endfunction

endpackage

// File: rtl/pulse_delay_line.sv
// Delays a single-bit pulse by DLY clocks through a shift register.
// Latency DLY clocks; DLY=0 is a straight wire.
// No backpressure; i_clr synchronously drops every pulse in flight.
module pulse_delay_line #(
    parameter int DLY = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_pulse,
    output logic o_pulse
);

    generate
        if (DLY == 0) begin : g_wire
            assign o_pulse = i_pulse;
        end else begin : g_shift
            logic [DLY-1:0] r_sr;

            // Shift the pulse one stage per clock; clear empties the whole line.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_sr <= '0;
                end else if (i_clr) begin
                    r_sr <= '0;
                end else begin
                    r_sr[0] <= i_pulse;
                    for (int k = 1; k < DLY; k++) begin
                        r_sr[k] <= r_sr[k-1];
                    end
                end
            end

            assign o_pulse = r_sr[DLY-1];
        end
    endgenerate

endmodule

// File: rtl/modulation_gen_mph.sv
// Multi-phase square-wave modulation generator with per-phase amplitude, saturating offset and step trigger.
// Output is registered: first phase appears 2 clocks after i_en is sampled high; step trigger trails each phase entry by TRIG_DLY.
// No backpressure; settings are shadowed and only take effect at a period boundary.
module modulation_gen_mph
    import mod_gen_pkg::*;
#(
    parameter int OUTPUT_BIT = 32,
    parameter int NUM_PHASE  = 4,
    parameter int TRIG_DLY   = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_en,
    input  logic [31:0]                     i_freq_cnt,
    input  logic [$clog2(NUM_PHASE):0]      i_nphase,
    input  logic [NUM_PHASE*OUTPUT_BIT-1:0] i_amp,
    input  logic [OUTPUT_BIT-1:0]           i_offset,
    output logic [OUTPUT_BIT-1:0]           o_mod_out,
    output logic [PHASE_W-1:0]              o_phase,
    output logic                            o_status,
    output logic                            o_stepTrig,
    output logic                            o_cycle_start
);

    state_t                          r_state;
    state_t                          w_state_nxt;

    logic [NUM_PHASE*OUTPUT_BIT-1:0] r_amp_sh;
    logic signed [OUTPUT_BIT-1:0]    r_offset_sh;
    logic [31:0]                     r_dwell_sh;
    logic [3:0]                      r_nphase_sh;

    logic [31:0]                     r_cnt;
    logic [PHASE_W-1:0]              r_phase;
    logic [OUTPUT_BIT-1:0]           r_mod_out;
    logic                            r_cycle_start;
    logic                            r_event;
    logic                            r_start;

    logic                            w_load_sh;
    logic                            w_enter;
    logic                            w_stop;
    logic                            w_last;
    logic [PHASE_W-1:0]              w_phase_nxt;

    logic [NUM_PHASE*OUTPUT_BIT-1:0] w_amp_src;
    logic signed [OUTPUT_BIT-1:0]    w_off_src;
    logic [31:0]                     w_dwell_src;
    logic signed [OUTPUT_BIT-1:0]    w_amp_sel;
    logic signed [63:0]              w_sum64;

    assign w_last = ({1'b0, r_phase} == (r_nphase_sh - 4'd1));

    // A wrap reloads the shadows on the same edge, so phase 0 must be built from the live inputs.
    assign w_amp_src   = w_load_sh ? i_amp      : r_amp_sh;
    assign w_off_src   = w_load_sh ? i_offset   : r_offset_sh;
    assign w_dwell_src = w_load_sh ? i_freq_cnt : r_dwell_sh;

    // Pick the amplitude of the phase being entered.
    always_comb begin
        w_amp_sel = '0;
        for (int k = 0; k < NUM_PHASE; k++) begin
            if (w_phase_nxt == PHASE_W'(k)) begin
                w_amp_sel = w_amp_src[k*OUTPUT_BIT +: OUTPUT_BIT];
            end
        end
    end

    assign w_sum64 = sat_add(64'(w_amp_sel), 64'(w_off_src), OUTPUT_BIT);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-edge control; a falling i_en takes priority over any phase boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_load_sh   = 1'b0;
        w_enter     = 1'b0;
        w_stop      = 1'b0;
        w_phase_nxt = r_phase;
        case (r_state)
            IDLE: begin
                if (i_en) begin
                    w_state_nxt = RUN;
                    w_load_sh   = 1'b1;
                end
            end
            RUN: begin
                if (!i_en) begin
                    w_state_nxt = IDLE;
                    w_stop      = 1'b1;
                end else if (r_start) begin
                    w_enter     = 1'b1;
                    w_phase_nxt = '0;
                end else if (r_cnt == 32'd0) begin
                    w_enter = 1'b1;
                    if (w_last) begin
                        w_phase_nxt = '0;
                        w_load_sh   = 1'b1;
                    end else begin
                        w_phase_nxt = r_phase + 3'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shadow registers, dwell counter, phase index and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_amp_sh      <= '0;
            r_offset_sh   <= '0;
            r_dwell_sh    <= '0;
            r_nphase_sh   <= '0;
            r_cnt         <= '0;
            r_phase       <= '0;
            r_mod_out     <= '0;
            r_cycle_start <= 1'b0;
            r_event       <= 1'b0;
            r_start       <= 1'b0;
        end else begin
            r_cycle_start <= 1'b0;
            r_event       <= 1'b0;
            if (w_load_sh) begin
                r_amp_sh    <= i_amp;
                r_offset_sh <= i_offset;
                r_dwell_sh  <= i_freq_cnt;
                r_nphase_sh <= clamp_nphase(8'(i_nphase), 4'(NUM_PHASE));
            end
            if (w_stop) begin
                r_mod_out <= '0;
                r_phase   <= '0;
                r_cnt     <= '0;
                r_start   <= 1'b0;
            end else if (r_state == IDLE) begin
                r_start <= i_en;
            end else if (w_enter) begin
                r_mod_out     <= w_sum64[OUTPUT_BIT-1:0];
                r_phase       <= w_phase_nxt;
                r_cnt         <= w_dwell_src;
                r_event       <= 1'b1;
                r_cycle_start <= (w_phase_nxt == '0);
                r_start       <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 32'd1;
            end
        end
    end

    pulse_delay_line #(
        .DLY (TRIG_DLY)
    ) u_trig_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_stop),
        .i_pulse (r_event),
        .o_pulse (o_stepTrig)
    );

    assign o_mod_out     = r_mod_out;
    assign o_phase       = r_phase;
    assign o_cycle_start = r_cycle_start;
    assign o_status      = (r_state == RUN) && ({1'b0, r_phase} >= (r_nphase_sh >> 1));

endmodule

// File: tb/tb_modulation_gen_mph.sv
module tb_modulation_gen_mph;
    import mod_gen_pkg::*;

    localparam int OB = 32;
    localparam int NP = 4;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_en;
    logic [31:0]     i_freq_cnt;
    logic [2:0]      i_nphase;
    logic [NP*OB-1:0] i_amp;
    logic [OB-1:0]   i_offset;
    logic [OB-1:0]   o_mod_out;
    logic [2:0]      o_phase;
    logic            o_status;
    logic            o_stepTrig;
    logic            o_cycle_start;

    int n_cmp = 0;
    int n_bad = 0;

    modulation_gen_mph #(
        .OUTPUT_BIT (OB),
        .NUM_PHASE  (NP),
        .TRIG_DLY   (2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (i_en),
        .i_freq_cnt    (i_freq_cnt),
        .i_nphase      (i_nphase),
        .i_amp         (i_amp),
        .i_offset      (i_offset),
        .o_mod_out     (o_mod_out),
        .o_phase       (o_phase),
        .o_status      (o_status),
        .o_stepTrig    (o_stepTrig),
        .o_cycle_start (o_cycle_start)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        logic [2:0]       nph;
        int               freq;
        logic [NP*OB-1:0] amp;
        logic [OB-1:0]    off;
        int               neff;
        logic [3:0][31:0] e;
        int               ncyc;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input logic [2:0] nph, input int freq,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3,
                                input logic [31:0] off, input int neff,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3,
                                input int ncyc);
        vec_t v;
        v.nph  = nph;
        v.freq = freq;
        v.amp  = {a3, a2, a1, a0};
        v.off  = off;
        v.neff = neff;
        v.e[0] = e0;
        v.e[1] = e1;
        v.e[2] = e2;
        v.e[3] = e3;
        v.ncyc = ncyc;
        return v;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        i_nphase   = v.nph;
        i_freq_cnt = v.freq;
        i_amp      = v.amp;
        i_offset   = v.off;
    endtask

    // Run one vector from IDLE, check every clock, then drop i_en and check the return to IDLE.
    task automatic run_vec(input int vi);
        vec_t v;
        int per, p, w;
        v = vecs[vi];
        per = v.freq + 1;
        apply(v);
        i_en = 1'b1;
        tick();
        chk($sformatf("v%0d start out", vi), 0, o_mod_out, 32'd0);
        chk($sformatf("v%0d start cs", vi), 0, 32'(o_cycle_start), 32'd0);
        chk($sformatf("v%0d start trig", vi), 0, 32'(o_stepTrig), 32'd0);
        for (int c = 0; c < v.ncyc; c++) begin
            tick();
            p = (c / per) % v.neff;
            w = c % per;
            chk($sformatf("v%0d out", vi), c, o_mod_out, v.e[p]);
            chk($sformatf("v%0d phase", vi), c, 32'(o_phase), 32'(p));
            chk($sformatf("v%0d status", vi), c, 32'(o_status), 32'(p >= v.neff / 2));
            chk($sformatf("v%0d cycle_start", vi), c, 32'(o_cycle_start), 32'(p == 0 && w == 0));
            chk($sformatf("v%0d stepTrig", vi), c, 32'(o_stepTrig), 32'(c >= 2 && ((c - 2) % per) == 0));
        end
        i_en = 1'b0;
        tick();
        chk($sformatf("v%0d stop out", vi), 0, o_mod_out, 32'd0);
        chk($sformatf("v%0d stop phase", vi), 0, 32'(o_phase), 32'd0);
        chk($sformatf("v%0d stop status", vi), 0, 32'(o_status), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("v%0d stop trig", vi), k, 32'(o_stepTrig), 32'd0);
            tick();
        end
    endtask

    initial begin
        vecs[0] = mk(3'd2, 3, -32'sd100, 32'sd100, 0, 0, 32'd0, 2,
                     -32'sd100, 32'sd100, 0, 0, 16);
        vecs[1] = mk(3'd4, 0, 32'd10, 32'd20, 32'd30, 32'd40, 32'd0, 4,
                     32'd10, 32'd20, 32'd30, 32'd40, 10);
        vecs[2] = mk(3'd2, 1, 32'h7FFF_FFF0, 32'h8000_0010, 0, 0, 32'h0000_0100, 2,
                     32'h7FFF_FFFF, 32'h8000_0110, 0, 0, 8);
        vecs[3] = mk(3'd2, 1, 32'h7FFF_FFF0, 32'h8000_0010, 0, 0, 32'hFFFF_FF00, 2,
                     32'h7FFF_FEF0, 32'h8000_0000, 0, 0, 8);
        vecs[4] = mk(3'd0, 0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 2,
                     32'd6, 32'd7, 0, 0, 8);
        vecs[5] = mk(3'd7, 1, 32'd1, 32'd2, 32'd3, 32'd4, 32'hFFFF_FFFF, 4,
                     32'd0, 32'd1, 32'd2, 32'd3, 16);
        vecs[6] = mk(3'd3, 2, 32'hFFFF_FFFB, 32'd0, 32'd5, 32'd99, 32'd10, 3,
                     32'd5, 32'd10, 32'd15, 0, 18);

        i_rst_n    = 1'b0;
        i_en       = 1'b0;
        i_freq_cnt = '0;
        i_nphase   = '0;
        i_amp      = '0;
        i_offset   = '0;
        #3;
        chk("reset out", 0, o_mod_out, 32'd0);
        chk("reset phase", 0, 32'(o_phase), 32'd0);
        chk("reset status", 0, 32'(o_status), 32'd0);
        chk("reset trig", 0, 32'(o_stepTrig), 32'd0);
        chk("reset cs", 0, 32'(o_cycle_start), 32'd0);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("idle out", 0, o_mod_out, 32'd0);
        chk("idle status", 0, 32'(o_status), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_vec(i);
        end

        // Settings changed mid-period only take effect at the next phase-0 entry.
        apply(vecs[1]);
        i_en = 1'b1;
        tick();
        tick();
        chk("shadow p0", 0, o_mod_out, 32'd10);
        tick();
        chk("shadow p1", 0, o_mod_out, 32'd20);
        i_amp[31:0] = 32'd99;
        i_freq_cnt  = 32'd1;
        tick();
        chk("shadow p2", 0, o_mod_out, 32'd30);
        tick();
        chk("shadow p3", 0, o_mod_out, 32'd40);
        tick();
        chk("shadow new p0", 0, o_mod_out, 32'd99);
        chk("shadow new cs", 0, 32'(o_cycle_start), 32'd1);
        tick();
        chk("shadow new p0 hold", 0, o_mod_out, 32'd99);
        chk("shadow new p0 hold cs", 0, 32'(o_cycle_start), 32'd0);
        tick();
        chk("shadow new p1", 0, o_mod_out, 32'd20);
        chk("shadow new p1 phase", 0, 32'(o_phase), 32'd1);
        i_en = 1'b0;
        tick();
        tick();

        // Asynchronous reset mid-run clears outputs before the next edge.
        apply(vecs[0]);
        i_en = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("pre-rst out", 0, o_mod_out, -32'sd100);
        chk("pre-rst trig", 0, 32'(o_stepTrig), 32'd1);
        i_rst_n = 1'b0;
        #2;
        chk("async rst out", 0, o_mod_out, 32'd0);
        chk("async rst phase", 0, 32'(o_phase), 32'd0);
        chk("async rst status", 0, 32'(o_status), 32'd0);
        chk("async rst trig", 0, 32'(o_stepTrig), 32'd0);
        chk("async rst cs", 0, 32'(o_cycle_start), 32'd0);
        i_en = 1'b0;
        #2;
        i_rst_n = 1'b1;
        tick();
        tick();
        chk("post-rst out", 0, o_mod_out, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
